// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder: one-word holding buffer in front of a shift register,
// emitting one bit per bit_en strobe with a sticky underrun flag.
module piso_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             x_out,
    output logic             x_valid,
    output logic             last_bit,
    output logic             underrun,
    input  logic             clear_underrun
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             underrun_q, underrun_d;

    logic             shifting;
    logic             is_last;
    logic             head_bit;
    logic [WIDTH-1:0] sreg_shifted;

    // Shift toward whichever end feeds x_out, zero fill.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head_bit     = sreg_q[WIDTH-1];
            assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head_bit     = sreg_q[0];
            assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign shifting = (state_q == SHIFT);
    assign is_last  = (cnt_q == LAST_CNT);

    assign in_ready = ~buf_full_q;
    assign x_valid  = shifting;
    assign x_out    = shifting & head_bit;
    assign last_bit = shifting & is_last;
    assign underrun = underrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;

        // An accept needs an empty buffer, so it never collides with a drain below.
        if (in_valid && !buf_full_q) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    sreg_d     = buf_q;
                    buf_full_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (!is_last) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CW'(1);
                    end else if (buf_full_q) begin
                        sreg_d     = buf_q;
                        buf_full_d = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over clear.
        if (bit_en && !shifting) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_bit_feeder.sv
// Directed bench for piso_bit_feeder: an MSB-first and an LSB-first instance share
// all inputs; each scenario task checks its own outputs against hand-computed values.
module tb_piso_bit_feeder;
    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       bit_en;
    logic       clear_underrun;

    logic in_ready, x_out, x_valid, last_bit, underrun;
    logic in_ready_l, x_out_l, x_valid_l, last_bit_l, underrun_l;

    int vectors;
    int miscompares;

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bit_en(bit_en), .x_out(x_out), .x_valid(x_valid),
        .last_bit(last_bit), .underrun(underrun), .clear_underrun(clear_underrun)
    );

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .bit_en(bit_en), .x_out(x_out_l), .x_valid(x_valid_l),
        .last_bit(last_bit_l), .underrun(underrun_l), .clear_underrun(clear_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; bit_en = 1'b0; clear_underrun = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({in_ready, x_valid, x_out, last_bit, underrun} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=10000", {in_ready, x_valid, x_out, last_bit, underrun});
        end
        $display("reset: ready=%b valid=%b x=%b last=%b underrun=%b", in_ready, x_valid, x_out, last_bit, underrun);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        in_data = w; in_valid = 1'b1;
        tick();                       // accept edge
        in_valid = 1'b0;
        vectors++;
        if (x_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after_accept got valid=%b ready=%b want valid=0 ready=0", x_valid, in_ready);
        end
        tick();                       // load edge
        bit_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (x_valid !== 1'b1 || x_out !== w[7-i] || last_bit !== (i == 7)) begin
                miscompares++;
                $display("FAIL single_bit%0d got v=%b x=%b last=%b want v=1 x=%b last=%b",
                         i, x_valid, x_out, last_bit, w[7-i], (i == 7));
            end
            $display("single: bit %0d x=%b last=%b", i, x_out, last_bit);
            tick();
        end
        vectors++;
        if (x_valid !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end got valid=%b underrun=%b want 0 0", x_valid, underrun);
        end
        tick();
        bit_en = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL single_underrun got=%b want=1", underrun);
        end
        $display("single: trailing strobe underrun=%b", underrun);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic        ready_exp;
        stream = 16'hA55A;
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        bit_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ready_exp = (i == 0) || (i >= 8);
            vectors++;
            if (x_valid !== 1'b1 || x_out !== stream[15-i] || last_bit !== ((i % 8) == 7)
                || in_ready !== ready_exp) begin
                miscompares++;
                $display("FAIL b2b_bit%0d got v=%b x=%b last=%b ready=%b want v=1 x=%b last=%b ready=%b",
                         i, x_valid, x_out, last_bit, in_ready, stream[15-i], ((i % 8) == 7), ready_exp);
            end
            $display("b2b: bit %0d x=%b last=%b ready=%b", i, x_out, last_bit, in_ready);
            if (i == 0) begin
                in_data = 8'h5A; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i == 15) bit_en = 1'b0;
        end
        vectors++;
        if (x_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end got valid=%b want=0", x_valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b1000_0000;      // transmit order of 8'h01, LSB first
        in_data = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        bit_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (x_valid_l !== 1'b1 || x_out_l !== exp_bits[7-i] || last_bit_l !== (i == 7)) begin
                miscompares++;
                $display("FAIL lsb_bit%0d got v=%b x=%b last=%b want v=1 x=%b last=%b",
                         i, x_valid_l, x_out_l, last_bit_l, exp_bits[7-i], (i == 7));
            end
            $display("lsb: bit %0d x=%b last=%b", i, x_out_l, last_bit_l);
            tick();
            if (i == 7) bit_en = 1'b0;
        end
        vectors++;
        if (x_valid_l !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_end got valid=%b want=0", x_valid_l);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w;
        w = 8'hC3;
        in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b0;
            tick();
            vectors++;
            if (x_valid !== 1'b1 || x_out !== w[7-i] || last_bit !== (i == 7)) begin
                miscompares++;
                $display("FAIL stall_hold%0d got v=%b x=%b last=%b want v=1 x=%b last=%b",
                         i, x_valid, x_out, last_bit, w[7-i], (i == 7));
            end
            $display("stall: bit %0d held x=%b last=%b", i, x_out, last_bit);
            bit_en = 1'b1;
            tick();
        end
        bit_en = 1'b0;
        vectors++;
        if (x_valid !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_end got valid=%b underrun=%b want 0 0", x_valid, underrun);
        end
    endtask

    task automatic test_underrun();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_set got=%b want=1", underrun);
        end
        repeat (2) tick();
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_sticky got=%b want=1", underrun);
        end
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_clear got=%b want=0", underrun);
        end
        clear_underrun = 1'b1; bit_en = 1'b1;
        tick();
        clear_underrun = 1'b0; bit_en = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_set_wins got=%b want=1", underrun);
        end
        $display("underrun: after set+clear underrun=%b", underrun);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        bit_en = 1'b1; in_data = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        bit_en = 1'b0;
        vectors++;
        if (x_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre got v=%b ready=%b x=%b want 1 0 1", x_valid, in_ready, x_out);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, x_valid, x_out, last_bit, underrun} !== 5'b10000) begin
            miscompares++;
            $display("FAIL midreset_async got=%b want=10000", {in_ready, x_valid, x_out, last_bit, underrun});
        end
        $display("midreset: ready=%b valid=%b", in_ready, x_valid);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (x_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL midreset_stale%0d got v=%b ready=%b want v=0 ready=1", i, x_valid, in_ready);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_stall();
        test_underrun();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
